// File: rtl/whac_pkg.sv
// Shared types and constants for the whac-a-mole mole spawner.
// Window lengths are in 1 ms ticks and must fit the 16-bit window counter.
package whac_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PICK    = 3'd1,
        PRESENT = 3'd2,
        ARMED   = 3'd3,
        ACTIVE  = 3'd4,
        EXPIRED = 3'd5
    } spawn_state_t;

    localparam logic [15:0] WIN_L0_MS = 16'd1500;
    localparam logic [15:0] WIN_L1_MS = 16'd1000;
    localparam logic [15:0] WIN_L2_MS = 16'd600;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    function automatic logic [15:0] level_to_ms(input logic [1:0] level);
        case (level)
            2'd0:    return WIN_L0_MS;
            2'd1:    return WIN_L1_MS;
            default: return WIN_L2_MS;
        endcase
    endfunction

endpackage

// File: rtl/mole_spawner_lfsr16.sv
// Free-running 16-bit Galois LFSR used as the mole index source.
// It advances every cycle so the pick depends on when the game asks for a mole.
module lfsr16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] seed,
    output logic [15:0] q
);
    import whac_pkg::*;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= seed;
        end else if (q[0]) begin
            q <= (q >> 1) ^ LFSR_MASK;
        end else begin
            q <= q >> 1;
        end
    end

endmodule

// File: rtl/mole_spawner.sv
// Mole spawner: picks a fresh mole, times its visibility window and
// returns the synchronised switch of the chosen mole to the game FSM.
//
// state   | meaning
// IDLE    | waiting for ready_for_mole
// PICK    | testing LFSR candidates until one is legal and new
// PRESENT | rng_ready pulse, index valid
// ARMED   | waiting for timeout_start, timer frozen
// ACTIVE  | window running, switchx live
// EXPIRED | timeout low until timeout_start drops
module mole_spawner #(
    parameter int          NUM_MOLES   = 8,
    parameter int          TICK_CYCLES = 50_000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [1:0]                   level,
    input  logic                         ready_for_mole,
    input  logic                         timeout_start,
    input  logic                         ledx,
    input  logic [NUM_MOLES-1:0]         switches,
    output logic                         rng_ready,
    output logic [$clog2(NUM_MOLES)-1:0] mole_idx,
    output logic [NUM_MOLES-1:0]         mole_leds,
    output logic                         timeout,
    output logic                         switchx
);
    import whac_pkg::*;

    localparam int IDX_W = $clog2(NUM_MOLES);
    localparam int PSC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(TICK_CYCLES - 1);
    localparam logic [IDX_W:0]   NUM_LIM  = NUM_MOLES[IDX_W:0];

    spawn_state_t          state;
    logic [15:0]           lfsr_q;
    logic [IDX_W-1:0]      cand;
    logic                  cand_ok;
    logic                  prev_valid;
    logic [15:0]           ms_left;
    logic [PSC_W-1:0]      psc;
    logic                  psc_wrap;
    logic [NUM_MOLES-1:0]  sync1;
    logic [NUM_MOLES-1:0]  sync2;
    logic                  sw_sel;
    logic [15-IDX_W:0]     lfsr_unused;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (LFSR_SEED),
        .q     (lfsr_q)
    );

    assign cand        = lfsr_q[IDX_W-1:0];
    assign lfsr_unused = lfsr_q[15:IDX_W];

    // mole_idx only changes on an accepted pick, so it doubles as the previous index.
    assign cand_ok  = ({1'b0, cand} < NUM_LIM) && !(prev_valid && (cand == mole_idx));
    assign psc_wrap = (psc == PSC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mole_idx   <= '0;
            prev_valid <= 1'b0;
            ms_left    <= '0;
            psc        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ready_for_mole) state <= PICK;
                end
                PICK: begin
                    if (cand_ok) begin
                        mole_idx   <= cand;
                        prev_valid <= 1'b1;
                        ms_left    <= level_to_ms(level);
                        psc        <= '0;
                        state      <= PRESENT;
                    end
                end
                PRESENT: state <= ARMED;
                ARMED: begin
                    if (timeout_start) state <= ACTIVE;
                end
                ACTIVE: begin
                    psc <= psc_wrap ? '0 : psc + 1'b1;
                    if (psc_wrap && (ms_left != 16'd0)) ms_left <= ms_left - 16'd1;
                    // A falling timeout_start beats expiry in the same cycle.
                    if (!timeout_start) begin
                        state <= IDLE;
                    end else if (ms_left == 16'd0) begin
                        state <= EXPIRED;
                    end
                end
                EXPIRED: begin
                    if (!timeout_start) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            sw_sel <= 1'b0;
        end else begin
            sync1  <= switches;
            sync2  <= sync1;
            sw_sel <= sync2[mole_idx];
        end
    end

    assign rng_ready = (state == PRESENT);
    assign timeout   = (state != EXPIRED);
    assign switchx   = sw_sel && (state == ACTIVE);

    // prev_valid keeps the LEDs dark from reset until a mole has actually been chosen.
    assign mole_leds = (NUM_MOLES'(1) << mole_idx) & {NUM_MOLES{ledx && prev_valid}};

endmodule

// File: tb/tb_mole_spawner.sv
// Directed bench for mole_spawner: an 8-mole instance for timing/hit/reset
// and a 6-mole instance for index legality and coverage.
module tb_mole_spawner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [1:0] level_a, level_b;
    logic       rfm_a, rfm_b, ts_a, ts_b, ledx_a, ledx_b;
    logic [7:0] sw_a;
    logic [5:0] sw_b;
    logic       rr_a, rr_b, to_a, to_b, sx_a, sx_b;
    logic [2:0] idx_a, idx_b;
    logic [7:0] leds_a;
    logic [5:0] leds_b;

    mole_spawner #(.NUM_MOLES(8), .TICK_CYCLES(4), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst_n(rst_n), .level(level_a), .ready_for_mole(rfm_a),
        .timeout_start(ts_a), .ledx(ledx_a), .switches(sw_a), .rng_ready(rr_a),
        .mole_idx(idx_a), .mole_leds(leds_a), .timeout(to_a), .switchx(sx_a)
    );

    mole_spawner #(.NUM_MOLES(6), .TICK_CYCLES(1), .LFSR_SEED(16'hACE1)) dut6 (
        .clk(clk), .rst_n(rst_n), .level(level_b), .ready_for_mole(rfm_b),
        .timeout_start(ts_b), .ledx(ledx_b), .switches(sw_b), .rng_ready(rr_b),
        .mole_idx(idx_b), .mole_leds(leds_b), .timeout(to_b), .switchx(sx_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int idx;
        int lat;
    } exp_t;
    exp_t sb[$];

    logic pv_a, pv_b;
    int   pidx_a, pidx_b;

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Reference LFSR: both instances share seed and reset, so one model covers both.
    logic [15:0] m_lfsr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= lstep(m_lfsr);
    end

    int rr_cnt_a = 0;
    int to_low_a = 0;
    always @(posedge clk) begin
        if (rr_a === 1'b1) rr_cnt_a++;
        if (to_a === 1'b0) to_low_a++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request in IDLE; returns the observed index with the block in ARMED.
    task automatic do_pick(input int which, output int got);
        logic [15:0] c;
        int   k, n, nm, pidx;
        logic pv, rr;
        exp_t e;
        nm   = (which == 0) ? 8 : 6;
        pv   = (which == 0) ? pv_a : pv_b;
        pidx = (which == 0) ? pidx_a : pidx_b;
        c = lstep(m_lfsr);
        k = 0;
        while (!((int'(c[2:0]) < nm) && !(pv && int'(c[2:0]) == pidx)) && k < 1000) begin
            c = lstep(c);
            k++;
        end
        sb.push_back('{idx: int'(c[2:0]), lat: 2 + k});
        if (which == 0) rfm_a = 1'b1; else rfm_b = 1'b1;
        tick();
        rfm_a = 1'b0;
        rfm_b = 1'b0;
        n = 1;
        rr = (which == 0) ? rr_a : rr_b;
        while (rr !== 1'b1 && n < 60) begin
            tick();
            n++;
            rr = (which == 0) ? rr_a : rr_b;
        end
        e = sb.pop_front();
        got = (which == 0) ? int'(idx_a) : int'(idx_b);
        check("rng_ready_seen", 32'(rr), 32'd1);
        check("pick_latency", n, e.lat);
        check("pick_idx", got, e.idx);
        if (which == 0) begin pv_a = 1'b1; pidx_a = e.idx; end
        else            begin pv_b = 1'b1; pidx_b = e.idx; end
        tick();
        check("rng_ready_pulse", 32'((which == 0) ? rr_a : rr_b), 32'd0);
    endtask

    // From ARMED: timeout_start rises one cycle after the pulse; returns just after ACTIVE entry.
    task automatic enter_active(input int which);
        if (which == 0) ts_a = 1'b1; else ts_b = 1'b1;
        tick();
    endtask

    task automatic run_expiry(input int which, input logic [1:0] lvl, input int exp_n);
        int   g, n;
        logic t;
        if (which == 0) level_a = lvl; else level_b = lvl;
        do_pick(which, g);
        if (which == 0) level_a = 2'd0; else level_b = 2'd0;
        enter_active(which);
        n = 0;
        t = (which == 0) ? to_a : to_b;
        while (t !== 1'b0 && n < 4000) begin
            tick();
            n++;
            t = (which == 0) ? to_a : to_b;
        end
        check("expiry_cycles", n, exp_n);
        repeat (3) tick();
        check("timeout_held_low", 32'((which == 0) ? to_a : to_b), 32'd0);
        if (which == 0) ts_a = 1'b0; else ts_b = 1'b0;
        tick();
        check("timeout_release", 32'((which == 0) ? to_a : to_b), 32'd1);
    endtask

    initial begin
        int   g, last, rr0, tl0;
        logic [7:0] seen;

        rst_n = 1'b0;
        level_a = 2'd0; level_b = 2'd0;
        rfm_a = 1'b0; rfm_b = 1'b0; ts_a = 1'b0; ts_b = 1'b0;
        ledx_a = 1'b1; ledx_b = 1'b1;
        sw_a = '0; sw_b = '0;
        pv_a = 1'b0; pv_b = 1'b0; pidx_a = 0; pidx_b = 0;
        #2;
        check("reset_timeout", 32'(to_a), 32'd1);
        check("reset_rng_ready", 32'(rr_a), 32'd0);
        check("reset_switchx", 32'(sx_a), 32'd0);
        check("reset_mole_idx", 32'(idx_a), 32'd0);
        check("reset_mole_leds", 32'(leds_a), 32'd0);
        tick();
        rst_n = 1'b1;

        // Seed 0xACE1 steps to 0xE270: first pick is mole 0 after two cycles.
        do_pick(0, g);
        check("first_pick_from_seed", g, 0);
        ts_a = 1'b1; tick(); ts_a = 1'b0; tick();

        rr0 = rr_cnt_a;
        run_expiry(0, 2'd2, 2401);
        check("single_rng_pulse", rr_cnt_a - rr0, 1);

        level_a = 2'd1;
        do_pick(0, g);
        enter_active(0);
        tl0 = to_low_a;
        repeat (40) tick();
        ledx_a = 1'b0;
        #1;
        check("leds_gated_off", 32'(leds_a), 32'd0);
        ledx_a = 1'b1;
        #1;
        check("leds_onehot", 32'(leds_a), 32'd1 << pidx_a);
        sw_a = 8'd1 << pidx_a;
        tick(); tick();
        check("switchx_not_yet", 32'(sx_a), 32'd0);
        tick();
        check("switchx_hit", 32'(sx_a), 32'd1);
        ts_a = 1'b0;
        tick();
        check("hit_switchx_idle", 32'(sx_a), 32'd0);
        check("hit_timeout_high", 32'(to_a), 32'd1);
        check("hit_no_expiry", to_low_a - tl0, 0);
        sw_a = '0;

        level_a = 2'd2;
        do_pick(0, g);
        enter_active(0);
        tl0 = to_low_a;
        repeat (2399) tick();
        ts_a = 1'b0;
        tick();
        check("collision_timeout", 32'(to_a), 32'd1);
        repeat (3) tick();
        check("collision_idle_timeout", 32'(to_a), 32'd1);
        check("collision_no_expiry", to_low_a - tl0, 0);

        run_expiry(1, 2'd3, 601);
        run_expiry(1, 2'd0, 1501);

        seen = '0;
        last = 0;
        for (int i = 0; i < 200; i++) begin
            do_pick(1, g);
            check("rand_in_range", 32'(g < 6), 32'd1);
            if (i > 0) check("rand_differs", 32'(g != last), 32'd1);
            seen[g[2:0]] = 1'b1;
            last = g;
            ts_b = 1'b1; tick(); ts_b = 1'b0; tick();
        end
        check("rand_all_seen", 32'(seen), 32'h3F);

        level_a = 2'd1;
        do_pick(0, g);
        enter_active(0);
        sw_a = 8'd1 << pidx_a;
        repeat (5) tick();
        check("pre_reset_switchx", 32'(sx_a), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_timeout", 32'(to_a), 32'd1);
        check("async_rst_leds", 32'(leds_a), 32'd0);
        check("async_rst_rng_ready", 32'(rr_a), 32'd0);
        check("async_rst_switchx", 32'(sx_a), 32'd0);
        check("async_rst_idx", 32'(idx_a), 32'd0);
        ts_a = 1'b0;
        sw_a = '0;
        pv_a = 1'b0; pv_b = 1'b0;
        tick();
        rst_n = 1'b1;
        do_pick(0, g);
        check("reseed_first_pick", g, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mole_spawner.md
# mole_spawner

Upstream companion to the whac-a-mole game FSM. It supplies that FSM's `rng_ready`, `timeout` and `switchx` inputs. When the FSM requests a mole, the block picks a pseudo-random mole index that differs from the previous one and drives that mole's LED. It then times the mole's visibility window for the selected difficulty level and reports the state of the selected switch back to the FSM.

## Interface
Parameters:
- `NUM_MOLES`, 8: number of mole LED/switch pairs; legal range 2..16.
- `TICK_CYCLES`, 50_000: clock cycles per 1 ms tick. Use small values in simulation.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `level` in 2: difficulty, sampled at mole pick. 0 → 1500 ms, 1 → 1000 ms, 2 and 3 → 600 ms.
- `ready_for_mole` in 1: FSM request for a new mole.
- `timeout_start` in 1: FSM is waiting for a hit; the window runs while this is high.
- `ledx` in 1: FSM enable for the mole LED.
- `switches` in NUM_MOLES: raw asynchronous player switches.
- `rng_ready` out 1: the new mole index is valid. Pulses for one cycle.
- `mole_idx` out $clog2(NUM_MOLES): the current mole.
- `mole_leds` out NUM_MOLES: one-hot of `mole_idx` gated by `ledx`.
- `timeout` out 1: 1 while time remains; 0 means the window has expired.
- `switchx` out 1: synchronised `switches[mole_idx]`, gated to the ACTIVE state.

## Operation
- LFSR:
  - 16-bit Galois, mask 16'hB400.
  - Advances every cycle, including while the block is idle.
  - Candidate index = low IDX_W bits of the LFSR.
- States:
  - IDLE: if `ready_for_mole` = 1, go to PICK.
  - PICK:
    - Reject the candidate if it is ≥ NUM_MOLES, or if it equals `prev_idx` while `prev_valid` = 1. On rejection, stay in PICK.
    - Otherwise: latch `mole_idx`, set `prev_idx` to the new index, set `prev_valid` = 1, load the window from `level`, clear the prescaler, and go to PRESENT.
  - PRESENT: `rng_ready` = 1 for this one cycle, then go to ARMED.
  - ARMED: wait for `timeout_start` = 1, then go to ACTIVE. The timer does not run in ARMED.
  - ACTIVE:
    - The prescaler counts to TICK_CYCLES−1 and then wraps. Each wrap decrements `ms_left`.
    - If `timeout_start` falls (a hit, or an FSM reset), go to IDLE.
    - Else, if `ms_left` = 0 after a decrement, go to EXPIRED.
  - EXPIRED: `timeout` = 0. Hold until `timeout_start` = 0, then go to IDLE.
- Outputs:
  - `timeout` = 0 only in EXPIRED.
  - `switchx` = 0 outside ACTIVE.
  - `mole_leds` = onehot(`mole_idx`) & {NUM_MOLES{`ledx`}}.
- Switch synchronisation: a 2-flop synchroniser on all `switches`, applied before the index mux.
- `ms_left` is 16 bits unsigned. Window constants must fit in 16 bits. The decrement never wraps below 0.
- Simultaneous events in ACTIVE: if the final tick and the fall of `timeout_start` occur in the same cycle, the fall wins and the block goes to IDLE. No expiry is reported.
- `level` changes after PICK do not affect the current mole.

## Timing
- Reset values:
  - State IDLE.
  - LFSR = LFSR_SEED.
  - `prev_valid` = 0.
  - `mole_idx` = 0, `mole_leds` = 0.
  - `rng_ready` = 0, `timeout` = 1, `switchx` = 0.
  - Synchroniser flops = 0.
- Request-to-valid latency: `ready_for_mole` high at cycle t → PICK at t+1 → earliest `rng_ready` at t+2. Each rejection adds one cycle.
- Handshake with the FSM: the FSM leaves its choose state on `rng_ready`. `timeout_start` then rises one cycle after the `rng_ready` pulse, which the ARMED state absorbs.
- Expiry time: `timeout` falls N×TICK_CYCLES + 1 cycles after entering ACTIVE, where N is the window in ms.
- `switchx` latency: 2 cycles from a `switches` edge, plus 1 cycle for the registered output.
- Reset mid-operation: asynchronous return to the reset values from any state. The LFSR reseeds.

## Structure
- Package `whac_pkg`:
  - `spawn_state_t` enum: IDLE, PICK, PRESENT, ARMED, ACTIVE, EXPIRED.
  - Window constants `WIN_L0_MS`, `WIN_L1_MS`, `WIN_L2_MS`.
  - Function `level_to_ms`.
- Sub-module `lfsr16`: inputs clk, rst_n, seed; output `q`. Advances every cycle.
- `mole_spawner` contains the FSM, prescaler, window counter, synchroniser and output decode.

## Test plan
- Reset mid-operation: `rst_n` = 0 during ACTIVE → asynchronously `timeout` = 1, `mole_leds` = 0, `rng_ready` = 0. After release, the first pick is derived from LFSR_SEED 16'hACE1.
- Expiry timing: TICK_CYCLES = 4, `level` = 2, `ready_for_mole` pulse then `timeout_start` held high → exactly one `rng_ready` pulse; `timeout` falls 2401 cycles after ACTIVE entry and stays 0 until `timeout_start` drops.
- Hit at level 1: `switches[mole_idx]` raised at ms 10 → `switchx` = 1 three cycles later. FSM drops `timeout_start` → IDLE, and `timeout` never goes low.
- Randomness, NUM_MOLES = 6: 200 consecutive picks → no index ≥ 6, no index equal to the previous pick, every index 0..5 seen.
- Tick/hit collision: `timeout_start` falls on the cycle of the last tick → IDLE with `timeout` = 1.
- LED gating: `ledx` = 0 in ACTIVE → `mole_leds` = 0. `ledx` = 1 → `mole_leds` = 1 << `mole_idx`.
